pmem_responder: RTL and testbench

- Physical-memory responder: the target end of the pmem read/write handshake driven by the L2 cache and the eviction write buffer.
- Accepts one line-sized read or write request at a time and services it after a fixed, parameterised latency.
- Pulses pmem_resp for one cycle per completed request.
- Serves as the memory model in system simulation and as the front end for a future real memory controller.

---
 rtl/pmem_responder.sv | 124 ++++++++++++
 tb/tb_pmem_responder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pmem_responder.sv
// rtl/pmem_responder.sv - fixed-latency physical-memory responder for line reads and writes
// A single request is captured in IDLE and completed with a one-cycle pmem_resp after LATENCY cycles.
module pmem_responder #(
    parameter int LATENCY    = 10,
    parameter int LINE_BITS  = 128,
    parameter int INDEX_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pmem_read,
    input  logic                 pmem_write,
    input  logic [15:0]          pmem_address,
    input  logic [LINE_BITS-1:0] pmem_wdata,
    output logic                 pmem_resp,
    output logic [LINE_BITS-1:0] pmem_rdata,
    output logic                 busy,
    output logic                 protocol_error
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    state_t                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   op_wr_q, op_wr_d;
    logic [INDEX_BITS-1:0]  index_q, index_d;
    logic [LINE_BITS-1:0]   wdata_q, wdata_d;
    logic [LINE_BITS-1:0]   rdata_q, rdata_d;
    logic                   perr_q, perr_d;
    logic [LINE_BITS-1:0]   mem_q [2**INDEX_BITS];

    logic                   req_any;
    logic                   req_held;
    logic                   addr_unused;

    assign req_any     = pmem_read | pmem_write;
    // Only the request line that was captured keeps the transaction alive.
    assign req_held    = op_wr_q ? pmem_write : pmem_read;
    assign addr_unused = ^{pmem_address[3:0], pmem_address[15:INDEX_BITS+4]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            index_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            index_q <= index_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            perr_q  <= perr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    state_d = (CNT_INIT == 8'd0) ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (!req_held) begin
                    state_d = IDLE;
                end else if (cnt_q <= 8'd1) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        index_d = index_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        perr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    op_wr_d = pmem_write;
                    index_d = pmem_address[INDEX_BITS+3:4];
                    wdata_d = pmem_write ? pmem_wdata : wdata_q;
                    cnt_d   = CNT_INIT;
                    perr_d  = pmem_write & pmem_read;
                end
            end
            BUSY: begin
                cnt_d  = cnt_q - 8'd1;
                perr_d = ~req_held;
            end
            default: ;
        endcase
        // Read data is latched on entry to RESP and then held until the next read completes.
        if (state_d == RESP && state_q != RESP && !op_wr_d) begin
            rdata_d = mem_q[index_d];
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == RESP && op_wr_q) begin
            mem_q[index_q] <= wdata_q;
        end
    end

    always_comb begin
        pmem_resp      = (state_q == RESP);
        busy           = (state_q != IDLE);
        protocol_error = perr_q;
        pmem_rdata     = rdata_q;
    end

endmodule

// File: tb/tb_pmem_responder.sv
// tb/tb_pmem_responder.sv - scoreboard bench for pmem_responder at LATENCY 10 and LATENCY 1
module tb_pmem_responder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rd = 1'b0, wr = 1'b0;
    logic [15:0]  addr = '0;
    logic [127:0] wdata = '0;
    logic         resp, busy, perr;
    logic [127:0] rdata;
    logic         rd1 = 1'b0, wr1 = 1'b0;
    logic [15:0]  addr1 = '0;
    logic [127:0] wdata1 = '0;
    logic         resp1, busy1, perr1;
    logic [127:0] rdata1;

    int n_checks = 0;
    int n_fail = 0;
    logic [127:0] exp_q[$];
    logic [127:0] model [256];
    logic [127:0] last_rd = '0;

    always #5 clk = ~clk;

    pmem_responder #(.LATENCY(10), .LINE_BITS(128), .INDEX_BITS(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .pmem_read(rd), .pmem_write(wr),
        .pmem_address(addr), .pmem_wdata(wdata), .pmem_resp(resp),
        .pmem_rdata(rdata), .busy(busy), .protocol_error(perr)
    );

    pmem_responder #(.LATENCY(1), .LINE_BITS(128), .INDEX_BITS(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .pmem_read(rd1), .pmem_write(wr1),
        .pmem_address(addr1), .pmem_wdata(wdata1), .pmem_resp(resp1),
        .pmem_rdata(rdata1), .busy(busy1), .protocol_error(perr1)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete request on the LATENCY=10 instance; address/data are scrambled after acceptance.
    task automatic xact(input bit is_wr, input bit both, input logic [15:0] a,
                        input logic [127:0] d, input string tag);
        int  lat = 0;
        int  perr_cnt = 0;
        bit  got = 0;
        if (!is_wr) exp_q.push_back(model[a[11:4]]);
        @(posedge clk); #1;
        wr = is_wr | both; rd = ~is_wr | both; addr = a; wdata = d;
        @(posedge clk); #1;
        addr = ~a; wdata = ~d;
        while (!got && lat < 300) begin
            @(negedge clk);
            lat++;
            if (perr) perr_cnt++;
            if (resp) got = 1;
        end
        check({tag, "_lat"}, lat, 10);
        check({tag, "_busy"}, busy, 1'b1);
        if (!is_wr) begin
            last_rd = exp_q.pop_front();
            check({tag, "_rdata"}, rdata, last_rd);
        end else begin
            model[a[11:4]] = d;
            check({tag, "_rdata_held"}, rdata, last_rd);
        end
        @(posedge clk); #1;
        rd = 0; wr = 0;
        @(negedge clk);
        if (perr) perr_cnt++;
        check({tag, "_resp_1wide"}, resp, 1'b0);
        check({tag, "_idle"}, busy, 1'b0);
        check({tag, "_perr_cnt"}, perr_cnt, both ? 1 : 0);
    endtask

    initial begin
        logic [127:0] line_a, line_b, line_g;
        int resp_cnt, perr_cnt;

        #2;
        check("rst_resp", resp, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_perr", perr, 1'b0);
        check("rst_rdata", rdata, '0);
        check("rst_busy1", busy1, 1'b0);
        check("rst_rdata1", rdata1, '0);
        #20 rst_n = 1'b1;

        // Basic write then read of the same line through a different byte offset
        xact(1, 0, 16'h1230, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, "t1_wr");
        xact(0, 0, 16'h1238, '0, "t1_rd");

        // Upper address bits alias onto the same line
        line_a = {$urandom, $urandom, $urandom, $urandom};
        line_b = {$urandom, $urandom, $urandom, $urandom};
        xact(1, 0, 16'h0120, line_a, "t2_wr_a");
        xact(0, 0, 16'h1120, '0, "t2_rd_alias");
        xact(1, 0, 16'h0130, line_b, "t2_wr_b");
        xact(0, 0, 16'h0130, '0, "t2_rd_b");
        xact(0, 0, 16'h0120, '0, "t2_rd_a");
        check("t2_a_const", last_rd, line_a);

        // Read and write both high: write wins, one error pulse
        xact(1, 1, 16'h0040, {128{1'b1}}, "t3_both");
        xact(0, 0, 16'h0040, '0, "t3_rd");
        check("t3_ones", last_rd, {128{1'b1}});

        // Abort: write request dropped during BUSY
        xact(1, 0, 16'h0300, 128'hD0D0_D0D0_0000_1111_2222_3333_4444_5555, "t4_old");
        @(posedge clk); #1;
        wr = 1; addr = 16'h0300; wdata = 128'hC;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1 wr = 0;
        resp_cnt = 0; perr_cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (resp) resp_cnt++;
            if (perr) perr_cnt++;
        end
        check("t4_no_resp", resp_cnt, 0);
        check("t4_perr", perr_cnt, 1);
        check("t4_idle", busy, 1'b0);
        xact(0, 0, 16'h0300, '0, "t4_rd_old");

        // Asynchronous reset in the middle of a write
        xact(1, 0, 16'h0500, 128'hEEEE_0000_EEEE_0000_1234_5678_9ABC_DEF0, "t5_old");
        @(posedge clk); #1;
        wr = 1; addr = 16'h0500; wdata = 128'hF;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("t5_rst_resp", resp, 1'b0);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_perr", perr, 1'b0);
        check("t5_rst_rdata", rdata, '0);
        wr = 0;
        last_rd = '0;
        #1 rst_n = 1'b1;
        xact(0, 0, 16'h0500, '0, "t5_rd");

        // LATENCY=1: eviction write followed immediately by a read of the same line
        line_g = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        wr1 = 1; addr1 = 16'h0700; wdata1 = line_g;
        @(posedge clk);
        @(negedge clk);
        check("t6_resp_c1", resp1, 1'b1);
        @(posedge clk); #1;
        wr1 = 0; rd1 = 1;
        @(negedge clk);
        check("t6_gap_c2", resp1, 1'b0);
        exp_q.push_back(line_g);
        @(posedge clk);
        @(negedge clk);
        check("t6_resp_c3", resp1, 1'b1);
        check("t6_rdata", rdata1, exp_q.pop_front());
        @(posedge clk); #1;
        rd1 = 0;
        @(negedge clk);
        check("t6_resp_end", resp1, 1'b0);
        check("t6_perr", perr1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
